// File: rtl/stopwatch_uart_reporter.sv
// Sends one "M:ST.t\r\n" snapshot of four BCD stopwatch digits into a UART TX FIFO.
// Optional macro REPORTER_BCD_CHECK_EN: out-of-range digits go out as '?' and raise sticky bcd_err.
module stopwatch_uart_reporter #(
  parameter logic [7:0] SEP_CHAR = 8'h3A,
  parameter logic [7:0] DEC_CHAR = 8'h2E
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic       busy,
  output logic       done_tick,
  output logic       bcd_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DONE = 2'd2} state_t;

  state_t     state_r;
  logic [2:0] idx_r;
  logic [3:0] snap3_r, snap2_r, snap1_r, snap0_r;
  logic       bad3_s, bad2_s, bad1_s, bad0_s;
  logic [7:0] byte_s;

  function automatic logic [7:0] to_ascii(input logic [3:0] digit, input logic bad);
    if (bad) begin
      return 8'h3F;
    end else begin
      return 8'h30 + {4'h0, digit};
    end
  endfunction

`ifdef REPORTER_BCD_CHECK_EN
  logic bcd_err_r;

  function automatic logic digit_bad(input logic [3:0] digit, input logic [3:0] max_digit);
    return (digit > max_digit);
  endfunction

  assign bad3_s  = digit_bad(snap3_r, 4'd9);
  assign bad2_s  = digit_bad(snap2_r, 4'd5);
  assign bad1_s  = digit_bad(snap1_r, 4'd9);
  assign bad0_s  = digit_bad(snap0_r, 4'd9);
  assign bcd_err = bcd_err_r;

  // Sticky error flag, set when an invalid digit set is captured into the snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_err_r <= 1'b0;
    end else if ((state_r == IDLE) && start &&
                 (digit_bad(d3, 4'd9) || digit_bad(d2, 4'd5) ||
                  digit_bad(d1, 4'd9) || digit_bad(d0, 4'd9))) begin
      bcd_err_r <= 1'b1;
    end
  end
`else
  assign bad3_s  = 1'b0;
  assign bad2_s  = 1'b0;
  assign bad1_s  = 1'b0;
  assign bad0_s  = 1'b0;
  assign bcd_err = 1'b0;
`endif

  // Message byte selected by the current index, built from the snapshot only
  always_comb begin
    byte_s = 8'h00;
    case (idx_r)
      3'd0:    byte_s = to_ascii(snap3_r, bad3_s);
      3'd1:    byte_s = SEP_CHAR;
      3'd2:    byte_s = to_ascii(snap2_r, bad2_s);
      3'd3:    byte_s = to_ascii(snap1_r, bad1_s);
      3'd4:    byte_s = DEC_CHAR;
      3'd5:    byte_s = to_ascii(snap0_r, bad0_s);
      3'd6:    byte_s = 8'h0D;
      3'd7:    byte_s = 8'h0A;
      default: byte_s = 8'h00;
    endcase
  end

  // FIFO write interface; the write strobe must follow tx_full within the same cycle
  always_comb begin
    wr_uart = 1'b0;
    w_data  = 8'h00;
    if (state_r == SEND) begin
      wr_uart = ~tx_full;
      w_data  = byte_s;
    end else begin
      wr_uart = 1'b0;
      w_data  = 8'h00;
    end
  end

  assign busy      = (state_r != IDLE);
  assign done_tick = (state_r == DONE);

  // Control FSM: snapshot capture, byte sequencing and completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= 3'd0;
      snap3_r <= 4'd0;
      snap2_r <= 4'd0;
      snap1_r <= 4'd0;
      snap0_r <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            snap3_r <= d3;
            snap2_r <= d2;
            snap1_r <= d1;
            snap0_r <= d0;
            idx_r   <= 3'd0;
            state_r <= SEND;
          end
        end
        SEND: begin
          if (!tx_full) begin
            if (idx_r == 3'd7) begin
              state_r <= DONE;
            end else begin
              idx_r <= idx_r + 3'd1;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_uart_reporter.sv
// Directed self-checking bench for stopwatch_uart_reporter: latency, stalls, snapshot
// isolation, ignored restarts, mid-message reset and digit checking.
module tb_stopwatch_uart_reporter;

  logic       clk = 1'b0;
  logic       rst_n, start, tx_full;
  logic [3:0] d3, d2, d1, d0;
  logic       wr_uart;
  logic [7:0] w_data;
  logic       busy, done_tick, bcd_err;

  always #5 clk = ~clk;

  stopwatch_uart_reporter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .d3       (d3),
    .d2       (d2),
    .d1       (d1),
    .d0       (d0),
    .tx_full  (tx_full),
    .wr_uart  (wr_uart),
    .w_data   (w_data),
    .busy     (busy),
    .done_tick(done_tick),
    .bcd_err  (bcd_err)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] got_b[16];
  int         got_c[16];
  int         n_wr, n_done, done_c;
  logic       busy_c[32];
  logic [7:0] exp_b[8];
  int         exp_c[8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Start in the current cycle (offset 0) and observe 20 following cycles
  task automatic run_msg(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                         input logic [3:0] e, input int stall_lo, input int stall_hi,
                         input int chg_at, input int restart_a, input int restart_b);
    n_wr = 0; n_done = 0; done_c = -1;
    d3 = a; d2 = b; d1 = c; d0 = e;
    tx_full = 1'b0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      next_cycle();
      start   = (cyc == restart_a) || (cyc == restart_b);
      tx_full = (cyc >= stall_lo) && (cyc <= stall_hi);
      if (cyc == chg_at) begin
        d3 = 4'd9; d2 = 4'd5; d1 = 4'd9; d0 = 4'd9;
      end
      #1;
      busy_c[cyc] = busy;
      if (wr_uart) begin
        if (n_wr < 16) begin
          got_b[n_wr] = w_data;
          got_c[n_wr] = cyc;
        end
        n_wr++;
      end
      if (done_tick) begin
        n_done++;
        done_c = cyc;
      end
    end
    start = 1'b0;
    tx_full = 1'b0;
  endtask

  task automatic check_msg(input string name, input int exp_done);
    check($sformatf("%s writes", name), n_wr, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s byte%0d", name, i), got_b[i], exp_b[i]);
      check($sformatf("%s cyc%0d", name, i), got_c[i], exp_c[i]);
    end
    check($sformatf("%s done_cnt", name), n_done, 1);
    check($sformatf("%s done_cyc", name), done_c, exp_done);
  endtask

  task automatic set_exp_default();
    exp_b = '{8'h33, 8'h3A, 8'h34, 8'h35, 8'h2E, 8'h37, 8'h0D, 8'h0A};
    for (int i = 0; i < 8; i++) exp_c[i] = i + 1;
  endtask

  initial begin
    int pre_wr, post_wr, post_done;
    rst_n = 1'b0; start = 1'b0; tx_full = 1'b0;
    d3 = 4'd0; d2 = 4'd0; d1 = 4'd0; d0 = 4'd0;
    next_cycle();
    next_cycle();
    check("rst busy", busy, 1'b0);
    check("rst wr_uart", wr_uart, 1'b0);
    check("rst w_data", w_data, 8'h00);
    check("rst done_tick", done_tick, 1'b0);
    check("rst bcd_err", bcd_err, 1'b0);
    rst_n = 1'b1;
    next_cycle();

    // Basic message and latency
    set_exp_default();
    run_msg(4'd3, 4'd4, 4'd5, 4'd7, 99, 0, -1, -1, -1);
    check_msg("basic", 9);
    check("basic busy N+9", busy_c[9], 1'b1);
    check("basic busy N+10", busy_c[10], 1'b0);
    check("idle w_data", w_data, 8'h00);
    check("idle wr_uart", wr_uart, 1'b0);

    // Three stall cycles at N+3..N+5
    set_exp_default();
    exp_c = '{1, 2, 6, 7, 8, 9, 10, 11};
    run_msg(4'd3, 4'd4, 4'd5, 4'd7, 3, 5, -1, -1, -1);
    check_msg("stall", 12);

    // Input digits change after capture
    set_exp_default();
    run_msg(4'd3, 4'd4, 4'd5, 4'd7, 99, 0, 2, -1, -1);
    check_msg("snapshot", 9);

    // Start pulses during SEND and on the last write are ignored
    set_exp_default();
    run_msg(4'd3, 4'd4, 4'd5, 4'd7, 99, 0, -1, 4, 8);
    check_msg("restart", 9);
    check("restart busy N+11", busy_c[11], 1'b0);

    // Reset at N+4 aborts the message
    d3 = 4'd3; d2 = 4'd4; d1 = 4'd5; d0 = 4'd7;
    start = 1'b1;
    pre_wr = 0; post_wr = 0; post_done = 0;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      next_cycle();
      start = 1'b0;
      #1;
      if (wr_uart) pre_wr++;
    end
    next_cycle();
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 1'b0);
    check("abort wr_uart", wr_uart, 1'b0);
    for (int cyc = 0; cyc < 6; cyc++) begin
      next_cycle();
      if (cyc == 2) rst_n = 1'b1;
      #1;
      if (wr_uart) post_wr++;
      if (done_tick) post_done++;
    end
    check("abort pre writes", pre_wr, 3);
    check("abort post writes", post_wr, 0);
    check("abort post done", post_done, 0);
    set_exp_default();
    run_msg(4'd3, 4'd4, 4'd5, 4'd7, 99, 0, -1, -1, -1);
    check_msg("after_abort", 9);

    // Out-of-range tens-of-seconds digit
    set_exp_default();
`ifdef REPORTER_BCD_CHECK_EN
    exp_b[2] = 8'h3F;
    run_msg(4'd3, 4'd7, 4'd5, 4'd7, 99, 0, -1, -1, -1);
    check_msg("bcd", 9);
    check("bcd_err set", bcd_err, 1'b1);
    rst_n = 1'b0;
    #1;
    check("bcd_err cleared", bcd_err, 1'b0);
    rst_n = 1'b1;
`else
    exp_b[2] = 8'h37;
    run_msg(4'd3, 4'd7, 4'd5, 4'd7, 99, 0, -1, -1, -1);
    check_msg("bcd", 9);
    check("bcd_err tied", bcd_err, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
